// File: rtl/replica_pkg.sv
// Shared types and defaults for the route store and the annealing replica around it.
package replica_pkg;

  // City index width and beats per route used as defaults throughout.
  localparam int CW_DEF    = 7;
  localparam int BEATS_DEF = 8;

  typedef logic [CW_DEF-1:0]   city_t;
  // One beat: eight cities, element i in bits [i*CW +: CW].
  typedef logic [8*CW_DEF-1:0] replica_data_t;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_FULL = 2'd2
  } route_state_t;

endpackage

// File: rtl/route_bank.sv
// One route bank: simple dual-port RAM, one write port, one registered read port.
module route_bank
  import replica_pkg::*;
#(
  parameter int AW = $clog2(BEATS_DEF),
  parameter int DW = 8 * CW_DEF
) (
  input  logic          clk,
  input  logic          we,
  input  logic [AW-1:0] waddr,
  input  logic [DW-1:0] wdata,
  input  logic [AW-1:0] raddr,
  output logic [DW-1:0] rdata
);

  logic [DW-1:0] mem [0:(2**AW)-1];
  logic [DW-1:0] rdata_d;
  logic [DW-1:0] rdata_q;

  // Array lookup for the read port; registered below.
  always_comb begin
    rdata_d = mem[raddr];
  end

  // Contents are never reset so a route survives a reset of the control logic.
  always_ff @(posedge clk) begin
    if (we) begin
      mem[waddr] <= wdata;
    end
    rdata_q <= rdata_d;
  end

  assign rdata = rdata_q;

endmodule

// File: rtl/route_store.sv
// Double-buffered route store: current route is streamed out once per pass while
// a candidate route is collected into the other bank, then committed or dropped.
//
// Stream semantics: rd_valid and wr_valid are pure qualifiers with no back-pressure.
// A beat transfers on every rising edge where its valid is high; rd_* always issues
// BEATS back-to-back beats per pass, wr_* may insert bubbles of any length.
module route_store
  import replica_pkg::*;
#(
  parameter int BEATS = BEATS_DEF,
  parameter int CW    = CW_DEF
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     init_we,
  input  logic [$clog2(BEATS)-1:0] init_addr,
  input  logic [8*CW-1:0]          init_data,
  input  logic                     rd_start,
  output logic                     rd_valid,
  output logic [8*CW-1:0]          rd_data,
  input  logic                     wr_valid,
  input  logic [8*CW-1:0]          wr_data,
  input  logic                     decide,
  input  logic                     accept,
  output logic                     busy,
  output logic                     full,
  output logic                     ovf,
  output route_state_t             dbg_state,
  output logic                     dbg_cur
);

  localparam int AW   = $clog2(BEATS);
  localparam int CNTW = AW + 1;
  localparam int DW   = 8 * CW;
  localparam logic [CNTW-1:0] LAST = CNTW'(BEATS);

  route_state_t    state_q, state_d;
  logic            cur_q, cur_d;
  logic [CNTW-1:0] rd_cnt_q, rd_cnt_d;
  logic [CNTW-1:0] wr_cnt_q, wr_cnt_d;
  logic            rd_valid_q, rd_valid_d;
  logic            ovf_q, ovf_d;

  logic [1:0]      bank_we;
  logic [AW-1:0]   waddr;
  logic [DW-1:0]   wdata;
  logic [AW-1:0]   raddr;
  logic [DW-1:0]   rdata0;
  logic [DW-1:0]   rdata1;

  // Next-state, counters, bank write steering and read address issue.
  // rd_cnt counts read addresses already issued; beat 0 is issued on rd_start.
  always_comb begin
    state_d    = state_q;
    cur_d      = cur_q;
    rd_cnt_d   = rd_cnt_q;
    wr_cnt_d   = wr_cnt_q;
    rd_valid_d = 1'b0;
    ovf_d      = ovf_q;
    bank_we    = 2'b00;
    waddr      = init_addr;
    wdata      = init_data;
    raddr      = '0;

    case (state_q)
      ST_IDLE: begin
        if (init_we) begin
          bank_we[cur_q] = 1'b1;
        end
        if (wr_valid) begin
          ovf_d = 1'b1;
        end
        if (rd_start) begin
          state_d    = ST_RUN;
          raddr      = '0;
          rd_valid_d = 1'b1;
          rd_cnt_d   = {{(CNTW-1){1'b0}}, 1'b1};
          wr_cnt_d   = '0;
        end
      end

      ST_RUN: begin
        if (rd_cnt_q < LAST) begin
          raddr      = rd_cnt_q[AW-1:0];
          rd_valid_d = 1'b1;
          rd_cnt_d   = rd_cnt_q + 1'b1;
        end
        if (wr_valid) begin
          if (wr_cnt_q < LAST) begin
            bank_we[~cur_q] = 1'b1;
            waddr           = wr_cnt_q[AW-1:0];
            wdata           = wr_data;
            wr_cnt_d        = wr_cnt_q + 1'b1;
            // Completion wins over any decide seen in this same cycle.
            if (wr_cnt_q == LAST - 1'b1) begin
              state_d = ST_FULL;
            end
          end else begin
            ovf_d = 1'b1;
          end
        end
      end

      ST_FULL: begin
        if (wr_valid) begin
          ovf_d = 1'b1;
        end
        if (decide) begin
          if (accept) begin
            cur_d = ~cur_q;
          end
          state_d = ST_IDLE;
        end
      end

      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  // Control registers; reset abandons any pass but leaves bank contents alone.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q    <= ST_IDLE;
      cur_q      <= 1'b0;
      rd_cnt_q   <= '0;
      wr_cnt_q   <= '0;
      rd_valid_q <= 1'b0;
      ovf_q      <= 1'b0;
    end else begin
      state_q    <= state_d;
      cur_q      <= cur_d;
      rd_cnt_q   <= rd_cnt_d;
      wr_cnt_q   <= wr_cnt_d;
      rd_valid_q <= rd_valid_d;
      ovf_q      <= ovf_d;
    end
  end

  route_bank #(.AW(AW), .DW(DW)) u_bank0 (
    .clk   (clk),
    .we    (bank_we[0] & ~reset),
    .waddr (waddr),
    .wdata (wdata),
    .raddr (raddr),
    .rdata (rdata0)
  );

  route_bank #(.AW(AW), .DW(DW)) u_bank1 (
    .clk   (clk),
    .we    (bank_we[1] & ~reset),
    .waddr (waddr),
    .wdata (wdata),
    .raddr (raddr),
    .rdata (rdata1)
  );

  // cur cannot change while a read is in flight, so selecting on cur_q is safe.
  assign rd_valid  = rd_valid_q;
  assign rd_data   = rd_valid_q ? (cur_q ? rdata1 : rdata0) : '0;
  assign busy      = (state_q != ST_IDLE);
  assign full      = (state_q == ST_FULL);
  assign ovf       = ovf_q;
  assign dbg_state = state_q;
  assign dbg_cur   = cur_q;

endmodule

// File: tb/tb_route_store.sv
// Directed bench for route_store: read beats are scored against an expected queue
// by a negedge monitor; control flags are checked inline by the driver.
module tb_route_store;
  import replica_pkg::*;

  localparam int BEATS = BEATS_DEF;
  localparam int CW    = CW_DEF;
  localparam int AW    = $clog2(BEATS);
  localparam int DW    = 8 * CW;

  logic          clk       = 1'b0;
  logic          reset     = 1'b1;
  logic          init_we   = 1'b0;
  logic [AW-1:0] init_addr = '0;
  logic [DW-1:0] init_data = '0;
  logic          rd_start  = 1'b0;
  logic          rd_valid;
  logic [DW-1:0] rd_data;
  logic          wr_valid  = 1'b0;
  logic [DW-1:0] wr_data   = '0;
  logic          decide    = 1'b0;
  logic          accept    = 1'b0;
  logic          busy;
  logic          full;
  logic          ovf;
  route_state_t  dbg_state;
  logic          dbg_cur;

  logic [DW-1:0] exp_q[$];
  logic [DW-1:0] mon_exp;
  logic [DW-1:0] junk = {DW{1'b1}};
  logic          rd_valid_prev = 1'b0;
  int            n_vec = 0;
  int            n_err = 0;
  int            beats_seen = 0;
  int            rises = 0;
  int            seen0;
  int            rise0;

  route_store #(.BEATS(BEATS), .CW(CW)) dut (
    .clk       (clk),
    .reset     (reset),
    .init_we   (init_we),
    .init_addr (init_addr),
    .init_data (init_data),
    .rd_start  (rd_start),
    .rd_valid  (rd_valid),
    .rd_data   (rd_data),
    .wr_valid  (wr_valid),
    .wr_data   (wr_data),
    .decide    (decide),
    .accept    (accept),
    .busy      (busy),
    .full      (full),
    .ovf       (ovf),
    .dbg_state (dbg_state),
    .dbg_cur   (dbg_cur)
  );

  // Clock and watchdog
  always #5 clk = ~clk;

  initial begin
    #100000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1);
  end

  // Route contents: sel 0 = identity (beat k -> 8k..8k+7), others are distinct routes.
  function automatic logic [CW-1:0] city(input int sel, input int pos);
    case (sel)
      0:       return CW'(pos);
      1:       return CW'(64 + pos);
      2:       return CW'(127 - pos);
      default: return CW'(3 * pos + 1);
    endcase
  endfunction

  function automatic logic [DW-1:0] beat(input int sel, input int k);
    logic [DW-1:0] b;
    b = '0;
    for (int i = 0; i < 8; i++) b[i*CW +: CW] = city(sel, 8 * k + i);
    return b;
  endfunction

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
    n_vec++;
    if (act !== req) begin
      n_err++;
      $display("FAIL %s actual=%0h required=%0h", name, act, req);
    end
  endtask

  // Driver tasks: inputs change 1 time unit after the rising edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic load_route(input int sel);
    for (int k = 0; k < BEATS; k++) begin
      init_we   = 1'b1;
      init_addr = AW'(k);
      init_data = beat(sel, k);
      tick();
    end
    init_we = 1'b0;
  endtask

  task automatic start_read(input int sel);
    for (int k = 0; k < BEATS; k++) exp_q.push_back(beat(sel, k));
    rd_start = 1'b1;
    tick();
    rd_start = 1'b0;
  endtask

  task automatic slot(input logic v, input logic [DW-1:0] d);
    wr_valid = v;
    wr_data  = d;
    tick();
    wr_valid = 1'b0;
  endtask

  task automatic drain(input string name, input int s0, input int r0);
    int n;
    n = 0;
    while (exp_q.size() != 0 && n < 40) begin
      tick();
      n++;
    end
    tick();
    check({name, "_left"}, 64'(exp_q.size()), 64'd0);
    check({name, "_beats"}, 64'(beats_seen - s0), 64'(BEATS));
    check({name, "_runs"}, 64'(rises - r0), 64'd1);
  endtask

  task automatic do_decide(input logic acc);
    decide = 1'b1;
    accept = acc;
    tick();
    decide = 1'b0;
    accept = 1'b0;
  endtask

  // Scoreboard monitor: every presented read beat must match the head of exp_q.
  initial begin
    forever begin
      @(negedge clk);
      if (rd_valid) begin
        if (!rd_valid_prev) rises++;
        beats_seen++;
        if (exp_q.size() == 0) begin
          n_vec++;
          n_err++;
          $display("FAIL rd_beat_unexpected actual=%0h required=none", rd_data);
        end else begin
          mon_exp = exp_q.pop_front();
          check("rd_beat", 64'(rd_data), 64'(mon_exp));
        end
      end
      rd_valid_prev = rd_valid;
    end
  end

  // Directed sequence
  initial begin
    tick();
    tick();
    check("rst_state", 64'(dbg_state), 64'(ST_IDLE));
    check("rst_cur", 64'(dbg_cur), 64'd0);
    check("rst_rd_valid", 64'(rd_valid), 64'd0);
    check("rst_rd_data", 64'(rd_data), 64'd0);
    check("rst_flags", {61'd0, busy, full, ovf}, 64'd0);
    reset = 1'b0;

    // Identity route; candidate with a bubble before beat 2, then rejected.
    load_route(0);
    seen0 = beats_seen; rise0 = rises;
    start_read(0);
    slot(1'b1, beat(1, 0));
    slot(1'b1, beat(1, 1));
    slot(1'b0, junk);
    for (int k = 2; k < 7; k++) slot(1'b1, beat(1, k));
    check("pre_full_state", 64'(dbg_state), 64'(ST_RUN));
    check("pre_full_flag", 64'(full), 64'd0);
    slot(1'b1, beat(1, 7));
    check("full_state", 64'(dbg_state), 64'(ST_FULL));
    check("full_busy", {62'd0, busy, full}, 64'd3);
    do_decide(1'b0);
    check("reject_state", 64'(dbg_state), 64'(ST_IDLE));
    check("reject_cur", 64'(dbg_cur), 64'd0);
    drain("orig_pass", seen0, rise0);

    // Rejected candidate leaves the identity route; stray decides and rd_start ignored.
    seen0 = beats_seen; rise0 = rises;
    start_read(0);
    for (int k = 0; k < 4; k++) slot(1'b1, beat(2, k));
    decide = 1'b1; accept = 1'b1;
    slot(1'b1, beat(2, 4));
    decide = 1'b0; accept = 1'b0;
    check("run_decide_state", 64'(dbg_state), 64'(ST_RUN));
    check("run_decide_cur", 64'(dbg_cur), 64'd0);
    rd_start = 1'b1;
    slot(1'b1, beat(2, 5));
    rd_start = 1'b0;
    slot(1'b1, beat(2, 6));
    decide = 1'b1; accept = 1'b1;
    slot(1'b1, beat(2, 7));
    decide = 1'b0; accept = 1'b0;
    check("same_cycle_state", 64'(dbg_state), 64'(ST_FULL));
    check("same_cycle_cur", 64'(dbg_cur), 64'd0);
    do_decide(1'b1);
    check("accept_state", 64'(dbg_state), 64'(ST_IDLE));
    check("accept_cur", 64'(dbg_cur), 64'd1);
    drain("reject_pass", seen0, rise0);

    // Committed candidate is read back; init_we in RUN ignored; ninth beat overflows.
    seen0 = beats_seen; rise0 = rises;
    start_read(2);
    slot(1'b1, beat(3, 0));
    init_we = 1'b1; init_addr = AW'(7); init_data = junk;
    slot(1'b1, beat(3, 1));
    init_we = 1'b0;
    for (int k = 2; k < 8; k++) slot(1'b1, beat(3, k));
    check("ovf_before", 64'(ovf), 64'd0);
    slot(1'b1, junk);
    check("ovf_ninth", 64'(ovf), 64'd1);
    check("ovf_state", 64'(dbg_state), 64'(ST_FULL));
    do_decide(1'b1);
    check("accept2_cur", 64'(dbg_cur), 64'd0);
    drain("commit_pass", seen0, rise0);
    seen0 = beats_seen; rise0 = rises;
    start_read(3);
    drain("ninth_pass", seen0, rise0);

    // Reset clears sticky ovf; wr_valid in IDLE sets it again.
    reset = 1'b1;
    tick();
    reset = 1'b0;
    check("ovf_cleared", 64'(ovf), 64'd0);
    check("reset_run_state", 64'(dbg_state), 64'(ST_IDLE));
    slot(1'b1, junk);
    check("ovf_idle", 64'(ovf), 64'd1);
    check("ovf_idle_state", 64'(dbg_state), 64'(ST_IDLE));

    // Reset while beat 5 is on the read port.
    load_route(0);
    seen0 = beats_seen;
    start_read(0);
    repeat (5) tick();
    reset = 1'b1;
    tick();
    reset = 1'b0;
    check("mid_rst_rd_valid", 64'(rd_valid), 64'd0);
    check("mid_rst_rd_data", 64'(rd_data), 64'd0);
    check("mid_rst_flags", {61'd0, busy, full, ovf}, 64'd0);
    check("mid_rst_state", 64'(dbg_state), 64'(ST_IDLE));
    check("mid_rst_beats", 64'(beats_seen - seen0), 64'd6);
    check("mid_rst_left", 64'(exp_q.size()), 64'd2);
    exp_q.delete();
    seen0 = beats_seen; rise0 = rises;
    start_read(0);
    drain("post_rst_pass", seen0, rise0);

    reset = 1'b1;
    tick();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/route_store.md
ROUTE_STORE -- requirements
Module: route_store

Interface
REQ-001 Parameter: BEATS, default 8; 8-city beats per route (route = 8*BEATS cities).
REQ-002 Parameter: CW, default 7; city index width.
REQ-003 clk  input  1  clock; all logic rising-edge.
REQ-004 reset  input  1  reset, synchronous, active-high.
REQ-005 init_we  input  1  write one beat of the initial route into the current bank.
REQ-006 init_addr  input  log2(BEATS)  beat index for init_we.
REQ-007 init_data  input  8*CW  beat data for init_we; element i = city at position 8*addr+i.
REQ-008 rd_start  input  1  pulse; start one read pass of the current route.
REQ-009 rd_valid  output  1  read beat valid; feeds opt_route out_data_i stream.
REQ-010 rd_data  output  8*CW  read beat.
REQ-011 wr_valid  input  1  candidate beat valid; driven by opt_route out_valid_o.
REQ-012 wr_data  input  8*CW  candidate beat; driven by opt_route out_data_o.
REQ-013 decide  input  1  pulse; Metropolis decision strobe.
REQ-014 accept  input  1  qualifies decide: 1 = commit candidate, 0 = discard.
REQ-015 busy  output  1  high in RUN or FULL.
REQ-016 full  output  1  high in FULL (candidate complete, awaiting decision).
REQ-017 ovf  output  1  sticky error: wr_valid seen outside RUN or beyond BEATS beats.

Function
REQ-018 Storage SHALL be two banks of BEATS x 8*CW; bank pointer cur (1 bit) selects the current route, ~cur the candidate.
REQ-019 FSM states SHALL be IDLE, RUN, FULL.
REQ-020 IDLE: init_we writes current bank at init_addr same cycle; rd_start -> RUN, clears rd and wr beat counters.
REQ-021 rd_start in RUN or FULL SHALL be ignored; init_we outside IDLE SHALL be ignored.
REQ-022 RUN read side: rd_valid SHALL be high exactly BEATS consecutive cycles, starting the cycle after rd_start, beats 0..BEATS-1 in order, no gaps.
REQ-023 RUN write side: each cycle with wr_valid high SHALL write wr_data to candidate bank at wr counter, then increment; wr_valid low cycles (bubbles) SHALL NOT advance the counter.
REQ-024 Write order SHALL be independent of read timing; bubbles of any length accepted.
REQ-025 When the BEATS-th candidate beat is written, FSM SHALL enter FULL the next cycle, regardless of whether read side finished.
REQ-026 wr_valid in IDLE or FULL SHALL set ovf and SHALL NOT write memory.
REQ-027 FULL: decide & accept SHALL toggle cur; decide & ~accept SHALL leave cur; both -> IDLE next cycle.
REQ-028 decide outside FULL SHALL be ignored.
REQ-029 decide and write-completion in same cycle: completion processed, decide ignored.
REQ-030 A read pass started after an accept SHALL return the committed candidate.
REQ-031 Counters SHALL be log2(BEATS)+1 bits; no wrap within a pass.
REQ-032 Read latency: 1 cycle from internal read address to rd_data (registered output).

Reset
REQ-033 reset SHALL force: state IDLE, cur 0, counters 0, rd_valid 0, rd_data 0, busy 0, full 0, ovf 0.
REQ-034 reset SHALL NOT clear bank contents; reset mid-RUN or mid-FULL abandons the pass, route in bank 0 retained.
REQ-035 reset has priority over every other input in the same cycle.

Structure
REQ-036 replica_data_t, city index width, BEATS default and route_state_t enum SHALL live in replica_pkg.
REQ-037 One sub-module route_bank (simple dual-port RAM, 1 write, 1 registered read) SHALL be instantiated twice.
REQ-038 No combinational path from wr_* or decide to rd_*.

Verification
REQ-039 Init beats k -> {8k..8k+7}, rd_start -> rd_valid 8 cycles, beat 3 = {24..31}.
REQ-040 Read pass, echo beats with one bubble at beat 2, decide accept=1 -> next read returns echoed data; cur=1.
REQ-041 Same as 040 with accept=0 -> next read returns original route; cur=0.
REQ-042 wr_valid 9 beats in one pass -> ninth beat sets ovf, memory unchanged, state FULL.
REQ-043 decide during RUN (beat 4) -> ignored, state stays RUN, full later asserts after beat 8.
REQ-044 reset during RUN at beat 5 -> IDLE, rd_valid 0 next cycle, subsequent read returns bank 0 original route.
